// File: rtl/flush_delay_line_pkg.sv
// Shared types and age helper for the flush delay line.
// Age is the distance of a branch ID from the oldest-branch pointer, modulo 2^BID_W.
package flush_pkg;

    localparam int DEFAULT_BID_W = 3;

    typedef logic [DEFAULT_BID_W-1:0] bid_t;

    typedef struct packed {
        logic v;
        bid_t bid;
    } flush_stage_t;

    function automatic bid_t bid_age(input bid_t bid, input bid_t head);
        return bid - head;
    endfunction

endpackage

// File: rtl/flush_delay_line_bid_age_cmp.sv
// Combinational age comparator: o_older is set when i_bid is strictly older
// than i_inflightBid, both measured relative to i_headBid.
module bid_age_cmp
    import flush_pkg::*;
#(
    parameter int BID_W = DEFAULT_BID_W
) (
    input  logic [BID_W-1:0] i_bid,
    input  logic [BID_W-1:0] i_inflightBid,
    input  logic [BID_W-1:0] i_headBid,
    output logic             o_older
);

    logic [BID_W-1:0] w_ageNew;
    logic [BID_W-1:0] w_ageOld;

    // Subtraction truncated to BID_W bits gives the modulo age directly.
    assign w_ageNew = i_bid - i_headBid;
    assign w_ageOld = i_inflightBid - i_headBid;
    assign o_older  = (w_ageNew < w_ageOld);

endmodule

// File: rtl/flush_delay_line.sv
// Delays a branch-mispredict flush by DEPTH cycles, dropping younger/equal
// flushes and letting an older flush cancel whatever is still in flight.
module flush_delay_line
    import flush_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int BID_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_in,
    input  logic [BID_W-1:0] bid_in,
    input  logic [BID_W-1:0] head_bid,
    output logic             flush_out,
    output logic [BID_W-1:0] bid_out,
    output logic             pending,
    output logic [CNT_W-1:0] drop_cnt
);

    // In-flight stages are 0..DEPTH-2; with DEPTH=1 one dummy slot keeps widths legal.
    localparam int NIF = (DEPTH > 1) ? DEPTH - 1 : 1;

    typedef struct packed {
        logic             v;
        logic [BID_W-1:0] bid;
    } stage_t;

    stage_t           r_stage [DEPTH];
    logic             r_pending;
    logic [CNT_W-1:0] r_dropCnt;

    stage_t           w_next [DEPTH];
    logic [NIF-1:0]   w_ifValid;
    logic [NIF-1:0]   w_older;
    logic [NIF-1:0]   w_nextIfValid;
    logic             w_anyInflight;
    logic             w_olderAll;
    logic             w_accept;
    logic             w_cancel;
    logic             w_drop;
    logic [3:0]       w_inc;
    logic [CNT_W+3:0] w_sum;
    logic [CNT_W-1:0] w_dropNext;
    logic             w_pendNext;

    for (genvar g = 0; g < NIF; g++) begin : g_cmp
        if (DEPTH > 1) begin : g_live
            assign w_ifValid[g]     = r_stage[g].v;
            assign w_nextIfValid[g] = w_next[g].v;
            bid_age_cmp #(
                .BID_W(BID_W)
            ) u_cmp (
                .i_bid         (bid_in),
                .i_inflightBid (r_stage[g].bid),
                .i_headBid     (head_bid),
                .o_older       (w_older[g])
            );
        end else begin : g_none
            assign w_ifValid[g]     = 1'b0;
            assign w_nextIfValid[g] = 1'b0;
            assign w_older[g]       = 1'b1;
        end
    end

    always_comb begin
        w_anyInflight = |w_ifValid;
        // Invalid slots never block acceptance, so an empty set always accepts.
        w_olderAll    = &(w_older | ~w_ifValid);
        w_accept      = flush_in && w_olderAll;
        w_cancel      = flush_in && w_anyInflight && w_olderAll;
        w_drop        = flush_in && !w_olderAll;

        w_next[0] = w_accept ? stage_t'{v: 1'b1, bid: bid_in} : '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_next[i] = w_cancel ? '0 : r_stage[i-1];
        end

        w_inc = '0;
        if (w_cancel) begin
            for (int i = 0; i < NIF; i++) begin
                w_inc = w_inc + {3'b000, w_ifValid[i]};
            end
        end else if (w_drop) begin
            w_inc = 4'd1;
        end

        // Widened sum so the saturation test cannot itself overflow.
        w_sum      = {4'b0000, r_dropCnt} + {{CNT_W{1'b0}}, w_inc};
        w_dropNext = (w_sum > {4'b0000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        w_pendNext = |w_nextIfValid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_pending <= 1'b0;
            r_dropCnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= w_next[i];
            end
            r_pending <= w_pendNext;
            r_dropCnt <= w_dropNext;
        end
    end

    assign flush_out = r_stage[DEPTH-1].v;
    assign bid_out   = r_stage[DEPTH-1].bid;
    assign pending   = r_pending;
    assign drop_cnt  = r_dropCnt;

endmodule
